matmul2x2_seq: RTL and testbench

- Downstream consumer of the 2x2 operand-load FSM.
- Takes the two loaded 2x2 matrices of unsigned 4-bit elements and computes C = A x B.
- Uses a single shared multiplier with a 2-cycle multiply-accumulate per element, computing elements sequentially.
- Starts on the rising edge of the upstream `active` flag, holds the results, and flags completion for display/output logic.

---
 rtl/matmul2x2_seq.sv | 122 ++++++++++++
 tb/tb_matmul2x2_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul2x2_seq.sv
// Sequential 2x2 unsigned matrix multiplier C = A x B sharing one multiplier.
// Each result element takes a two-cycle multiply-accumulate; elements are produced in row-major order.
module matmul2x2_seq #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 2*DATA_W+1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              active,
    input  logic [DATA_W-1:0] A00,
    input  logic [DATA_W-1:0] A01,
    input  logic [DATA_W-1:0] A10,
    input  logic [DATA_W-1:0] A11,
    input  logic [DATA_W-1:0] B00,
    input  logic [DATA_W-1:0] B01,
    input  logic [DATA_W-1:0] B10,
    input  logic [DATA_W-1:0] B11,
    output logic [RES_W-1:0]  C00,
    output logic [RES_W-1:0]  C01,
    output logic [RES_W-1:0]  C10,
    output logic [RES_W-1:0]  C11,
    output logic              busy,
    output logic              done,
    output logic              valid
);

    typedef enum logic [1:0] {IDLE, MUL0, MUL1, DONE} state_t;

    state_t              state, state_nx;
    logic                active_q;
    logic                start;
    logic [DATA_W-1:0]   a_s [4];
    logic [DATA_W-1:0]   b_s [4];
    logic [1:0]          idx;
    logic [RES_W-1:0]    acc;
    logic [RES_W-1:0]    c_r [4];
    logic                k_sel;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [2*DATA_W-1:0] prod;

    function automatic logic [RES_W-1:0] widen(input logic [2*DATA_W-1:0] p);
        return {{(RES_W-2*DATA_W){1'b0}}, p};
    endfunction

    assign start = active & ~active_q;

    // Operand select: MUL0 uses A[i][0]*B[0][j], MUL1 uses A[i][1]*B[1][j]
    assign k_sel = (state == MUL1);
    assign op_a  = a_s[{idx[1], k_sel}];
    assign op_b  = b_s[{k_sel, idx[0]}];
    assign prod  = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            active_q <= 1'b0;
        end else begin
            state    <= state_nx;
            active_q <= active;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MUL0;
            MUL0:    state_nx = MUL1;
            MUL1:    state_nx = (idx == 2'd3) ? DONE : MUL0;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MUL0) || (state == MUL1);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            idx   <= 2'd0;
            acc   <= '0;
            valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                a_s[k] <= '0;
                b_s[k] <= '0;
                c_r[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_s[0] <= A00;
                        a_s[1] <= A01;
                        a_s[2] <= A10;
                        a_s[3] <= A11;
                        b_s[0] <= B00;
                        b_s[1] <= B01;
                        b_s[2] <= B10;
                        b_s[3] <= B11;
                        idx    <= 2'd0;
                        valid  <= 1'b0;
                    end
                end
                MUL0: acc <= widen(prod);
                MUL1: begin
                    c_r[idx] <= acc + widen(prod);
                    if (idx == 2'd3) valid <= 1'b1;
                    else             idx   <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign C00 = c_r[0];
    assign C01 = c_r[1];
    assign C10 = c_r[2];
    assign C11 = c_r[3];

endmodule

// File: tb/tb_matmul2x2_seq.sv
// Testbench for matmul2x2_seq: table-driven runs with a scoreboard queue plus
// hand-written sequences for edge timing, level hold, snapshot and mid-run reset.
module tb_matmul2x2_seq;

    typedef struct packed {
        logic [8:0] c00, c01, c10, c11;
    } res_t;

    typedef struct packed {
        logic [15:0] a, b;
        res_t        r;
    } vec_t;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       active = 1'b0;
    logic [3:0] A00, A01, A10, A11, B00, B01, B10, B11;
    logic [8:0] C00, C01, C10, C11;
    logic       busy, done, valid;

    int   ncmp = 0;
    int   nfail = 0;
    res_t sb_q [$];
    vec_t vecs [4];

    matmul2x2_seq #(.DATA_W(4)) dut (
        .clk(clk), .nRST(nRST), .active(active),
        .A00(A00), .A01(A01), .A10(A10), .A11(A11),
        .B00(B00), .B01(B01), .B10(B10), .B11(B11),
        .C00(C00), .C01(C01), .C10(C10), .C11(C11),
        .busy(busy), .done(done), .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
        {A00, A01, A10, A11} = a;
        {B00, B01, B10, B11} = b;
    endtask

    task automatic chk_c(input string tag, input res_t r);
        chk({tag, "_C00"}, C00, r.c00);
        chk({tag, "_C01"}, C01, r.c01);
        chk({tag, "_C10"}, C10, r.c10);
        chk({tag, "_C11"}, C11, r.c11);
    endtask

    task automatic check_pop(input string tag);
        res_t r;
        if (sb_q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL %s_sb: got empty scoreboard, expected one entry", tag);
        end else begin
            r = sb_q.pop_front();
            chk_c(tag, r);
            chk({tag, "_valid"}, valid, 1);
        end
    endtask

    // Raises active; returns just after E0 (the accepting edge)
    task automatic begin_run(input string tag, input vec_t v, input bit push);
        set_ops(v.a, v.b);
        if (push) sb_q.push_back(v.r);
        active = 1'b1;
        tick;
        chk({tag, "_busy_e0"}, busy, 1);
    endtask

    // Runs from just after E0 until done; optional disturbance at E3/E4
    task automatic finish_run(input string tag, input bit disturb);
        int  n = 0;
        int  busy_cnt = 1;
        int  vld_hi = 0;
        bit  seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick;
            n++;
            if (disturb && n == 3) begin
                set_ops(16'hFFFF, 16'hFFFF);
                active = 1'b0;
            end
            if (disturb && n == 4) active = 1'b1;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (valid) vld_hi++;
            end
        end
        if (!seen) begin
            ncmp++;
            nfail++;
            $display("FAIL %s_done_timeout: got no done pulse, expected one within 20 cycles", tag);
        end else begin
            chk({tag, "_done_edge"}, n, 8);
            chk({tag, "_busy_cycles"}, busy_cnt, 8);
            chk({tag, "_valid_low_during"}, vld_hi, 0);
            check_pop(tag);
            tick;
            chk({tag, "_done_one_cycle"}, done, 0);
            chk({tag, "_idle_busy"}, busy, 0);
        end
    endtask

    initial begin
        vec_t gen;
        vec_t ident;
        res_t prev;
        int   dones;

        vecs[0] = '{a: 16'h1001, b: 16'h3456, r: '{c00: 9'd3,   c01: 9'd4,   c10: 9'd5,   c11: 9'd6}};
        vecs[1] = '{a: 16'h1234, b: 16'h5678, r: '{c00: 9'd19,  c01: 9'd22,  c10: 9'd43,  c11: 9'd50}};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, r: '{c00: 9'h1C2, c01: 9'h1C2, c10: 9'h1C2, c11: 9'h1C2}};
        vecs[3] = '{a: 16'h2013, b: 16'h4567, r: '{c00: 9'd8,   c01: 9'd10,  c10: 9'd22,  c11: 9'd26}};
        ident = vecs[0];
        gen   = vecs[1];

        set_ops(16'h0000, 16'h0000);
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk_c("rst", '0);
        nRST = 1'b1;
        tick;

        for (int i = 0; i < 4; i++) begin
            begin_run($sformatf("vec%0d", i), vecs[i], 1'b1);
            finish_run($sformatf("vec%0d", i), 1'b0);
            active = 1'b0;
            tick;
        end

        // Per-edge write timing: old values persist until each element's even edge
        prev = vecs[3].r;
        begin_run("edges", gen, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk($sformatf("edges_e%0d_C00", k), C00, (k >= 2) ? gen.r.c00 : prev.c00);
            chk($sformatf("edges_e%0d_C01", k), C01, (k >= 4) ? gen.r.c01 : prev.c01);
            chk($sformatf("edges_e%0d_C10", k), C10, (k >= 6) ? gen.r.c10 : prev.c10);
            chk($sformatf("edges_e%0d_C11", k), C11, (k >= 8) ? gen.r.c11 : prev.c11);
            chk($sformatf("edges_e%0d_valid", k), valid, (k == 8) ? 1 : 0);
            chk($sformatf("edges_e%0d_done", k), done, (k == 8) ? 1 : 0);
        end
        check_pop("edges");
        active = 1'b0;
        tick;

        // Level hold: one pulse only, result stays put
        dones = 0;
        begin_run("hold", ident, 1'b1);
        for (int k = 0; k < 39; k++) begin
            tick;
            if (done) begin
                dones++;
                check_pop("hold");
            end
        end
        chk("hold_done_count", dones, 1);
        chk_c("hold_stable", ident.r);
        chk("hold_valid", valid, 1);
        active = 1'b0;
        tick;
        begin_run("rerun", gen, 1'b1);
        chk("rerun_valid_low", valid, 0);
        finish_run("rerun", 1'b0);
        active = 1'b0;
        tick;

        // Snapshot: inputs go to 15 at E3, active re-rises while busy
        begin_run("snap", gen, 1'b1);
        finish_run("snap", 1'b1);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done) dones++;
        end
        chk("snap_no_retrigger", dones, 0);
        chk("snap_busy", busy, 0);
        active = 1'b0;
        tick;

        // Reset after E5
        begin_run("rstmid", gen, 1'b0);
        for (int k = 0; k < 5; k++) tick;
        nRST = 1'b0;
        #2;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", valid, 0);
        chk("rstmid_done", done, 0);
        chk_c("rstmid", '0);
        active = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (done) dones++;
        end
        chk("rstmid_no_done", dones, 0);
        nRST = 1'b1;
        tick;
        chk("rstmid_idle_after", busy, 0);
        begin_run("post_rst", ident, 1'b1);
        finish_run("post_rst", 1'b0);
        active = 1'b0;
        tick;

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
